mouse_tracker: RTL and testbench



---
 rtl/mouse_pkg.sv | 36 +++
 rtl/mouse_tracker_axis_accumulator.sv | 61 ++++++
 rtl/mouse_tracker.sv | 154 +++++++++++++++
 tb/tb_mouse_tracker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_pkg
// Description : Shared types and constants for the PS/2 mouse tracker:
//               packet-decoder state encoding, default geometry/timeout
//               values and PS/2 header bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

    // Packet decoder states
    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } state_t;

    // Default screen geometry, reset position and inter-byte timeout
    localparam int X_MAX          = 319;
    localparam int Y_MAX          = 239;
    localparam int X_INIT         = 160;
    localparam int Y_INIT         = 120;
    localparam int TIMEOUT_CYCLES = 2_500_000;

    // Bit positions inside the PS/2 header byte
    localparam int LEFT  = 0;
    localparam int RIGHT = 1;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

endpackage : mouse_pkg
`default_nettype wire

// File: rtl/mouse_tracker_axis_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : axis_accumulator
// Description : One cursor axis. Adds a 9-bit signed PS/2 delta (optionally
//               negated or forced to zero) to the registered position and
//               clamps the result to [0, MAX] before it is stored, so the
//               output is never out of range.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_accumulator #(
    parameter int WIDTH = 9,
    parameter int MAX   = 319,
    parameter int INIT  = 160
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic signed [8:0] delta_i,
    input  logic              negate_i,
    input  logic              zero_i,
    input  logic              load_i,
    output logic [WIDTH-1:0]  pos_o
);

    // 11 bits covers position (up to 319) plus/minus a full 9-bit delta.
    localparam int AW = 11;
    localparam logic signed [AW-1:0] MAX_S = AW'(MAX);

    logic [WIDTH-1:0]     pos_q;
    logic [WIDTH-1:0]     pos_d;
    logic signed [AW-1:0] delta_ext;
    logic signed [AW-1:0] step;
    logic signed [AW-1:0] sum;

    // Signed add of the effective delta, then clamp into the legal range
    always_comb begin
        delta_ext = {{(AW-9){delta_i[8]}}, delta_i};
        step      = zero_i ? '0 : (negate_i ? -delta_ext : delta_ext);
        sum       = $signed({{(AW-WIDTH){1'b0}}, pos_q}) + step;
        pos_d     = pos_q;
        if (sum[AW-1]) begin
            pos_d = '0;
        end else if (sum > MAX_S) begin
            pos_d = WIDTH'(MAX);
        end else begin
            pos_d = sum[WIDTH-1:0];
        end
    end

    // Position register, updated only when a packet is applied
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q <= WIDTH'(INIT);
        end else if (load_i) begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule : axis_accumulator
`default_nettype wire

// File: rtl/mouse_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mouse_tracker
// Description : Decodes 3-byte PS/2 mouse packets into a clamped absolute
//               cursor position plus button levels, a packet-applied pulse
//               and a left-click pulse. Resyncs on header bit 3 and drops
//               partial packets after an inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_tracker #(
    parameter int X_MAX          = mouse_pkg::X_MAX,
    parameter int Y_MAX          = mouse_pkg::Y_MAX,
    parameter int X_INIT         = mouse_pkg::X_INIT,
    parameter int Y_INIT         = mouse_pkg::Y_INIT,
    parameter int TIMEOUT_CYCLES = mouse_pkg::TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic [7:0] iByte,
    input  logic       iByteValid,
    output logic [8:0] oMouseX,
    output logic [7:0] oMouseY,
    output logic       oLeft,
    output logic       oRight,
    output logic       oPacketValid,
    output logic       oClick
);

    import mouse_pkg::*;

    localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

    state_t        state_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    hdr_q;
    logic [7:0]    dx_q;
    logic [7:0]    dy_q;
    logic          left_q;
    logic          right_q;
    logic          pkt_valid_q;
    logic          click_q;

    logic          apply;
    logic [8:0]    dx;
    logic [8:0]    dy;
    logic          unused_hdr;

    assign apply      = (state_q == APPLY);
    assign dx         = {hdr_q[XSIGN], dx_q};
    assign dy         = {hdr_q[YSIGN], dy_q};
    // Bit 2 is reserved and bit 3 is always 1 once a header is accepted.
    assign unused_hdr = ^{hdr_q[2], hdr_q[SYNC]};

    // Packet FSM with gap counter, button levels and one-cycle pulses
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state_q     <= WAIT_B0;
            gap_q       <= '0;
            hdr_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
            click_q     <= 1'b0;
        end else begin
            pkt_valid_q <= apply;
            click_q     <= apply & hdr_q[LEFT] & ~left_q;
            if (apply) begin
                left_q  <= hdr_q[LEFT];
                right_q <= hdr_q[RIGHT];
            end

            case (state_q)
                // APPLY treats a concurrent byte exactly like WAIT_B0 so
                // back-to-back packets lose nothing.
                WAIT_B0, APPLY: begin
                    gap_q <= '0;
                    if (iByteValid && iByte[SYNC]) begin
                        hdr_q   <= iByte;
                        state_q <= WAIT_B1;
                    end else begin
                        state_q <= WAIT_B0;
                    end
                end
                WAIT_B1: begin
                    if (iByteValid) begin
                        dx_q    <= iByte;
                        gap_q   <= '0;
                        state_q <= WAIT_B2;
                    end else if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= WAIT_B0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                WAIT_B2: begin
                    if (iByteValid) begin
                        dy_q    <= iByte;
                        gap_q   <= '0;
                        state_q <= APPLY;
                    end else if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= WAIT_B0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    gap_q   <= '0;
                    state_q <= WAIT_B0;
                end
            endcase
        end
    end

    axis_accumulator #(
        .WIDTH (9),
        .MAX   (X_MAX),
        .INIT  (X_INIT)
    ) u_axis_x (
        .clk      (clk),
        .rst_ni   (iResetn),
        .delta_i  (dx),
        .negate_i (1'b0),
        .zero_i   (hdr_q[XOVF]),
        .load_i   (apply),
        .pos_o    (oMouseX)
    );

    // PS/2 Y grows upward while the screen grows downward, hence negate.
    axis_accumulator #(
        .WIDTH (8),
        .MAX   (Y_MAX),
        .INIT  (Y_INIT)
    ) u_axis_y (
        .clk      (clk),
        .rst_ni   (iResetn),
        .delta_i  (dy),
        .negate_i (1'b1),
        .zero_i   (hdr_q[YOVF]),
        .load_i   (apply),
        .pos_o    (oMouseY)
    );

    assign oLeft        = left_q;
    assign oRight       = right_q;
    assign oPacketValid = pkt_valid_q;
    assign oClick       = click_q;

endmodule : mouse_tracker
`default_nettype wire

// File: tb/tb_mouse_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_tracker
// Description : Directed self-checking bench for mouse_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_tracker;

    logic       clk;
    logic       iResetn;
    logic [7:0] iByte;
    logic       iByteValid;
    logic [8:0] oMouseX;
    logic [7:0] oMouseY;
    logic       oLeft;
    logic       oRight;
    logic       oPacketValid;
    logic       oClick;

    int checks = 0;
    int errors = 0;

    mouse_tracker #(
        .X_MAX          (319),
        .Y_MAX          (239),
        .X_INIT         (160),
        .Y_INIT         (120),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .iResetn      (iResetn),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oMouseX      (oMouseX),
        .oMouseY      (oMouseY),
        .oLeft        (oLeft),
        .oRight       (oRight),
        .oPacketValid (oPacketValid),
        .oClick       (oClick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one cycle
    task automatic send_byte(input logic [7:0] b);
        iByte      = b;
        iByteValid = 1'b1;
        tick();
        iByteValid = 1'b0;
        iByte      = 8'h00;
    endtask

    // Three consecutive bytes; returns just after the edge sampling byte 2
    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic test_reset();
        iResetn    = 1'b0;
        iByte      = 8'h00;
        iByteValid = 1'b0;
        #12;
        checks++;
        if ({oMouseX, oMouseY} !== {9'd160, 8'd120}) begin
            errors++;
            $display("FAIL reset_pos got X=%0d Y=%0d exp X=160 Y=120", oMouseX, oMouseY);
        end
        checks++;
        if ({oLeft, oRight, oPacketValid, oClick} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {oLeft, oRight, oPacketValid, oClick});
        end
        tick();
        iResetn = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        send_packet(8'h08, 8'h05, 8'h03);
        checks++;
        if ({oMouseX, oMouseY, oPacketValid} !== {9'd160, 8'd120, 1'b0}) begin
            errors++;
            $display("FAIL nominal_early got X=%0d Y=%0d pv=%b exp X=160 Y=120 pv=0", oMouseX, oMouseY, oPacketValid);
        end
        tick();
        checks++;
        if ({oMouseX, oMouseY} !== {9'd165, 8'd117}) begin
            errors++;
            $display("FAIL nominal_pos got X=%0d Y=%0d exp X=165 Y=117", oMouseX, oMouseY);
        end
        checks++;
        if ({oPacketValid, oClick, oLeft} !== 3'b100) begin
            errors++;
            $display("FAIL nominal_flags got pv/click/left=%b exp 100", {oPacketValid, oClick, oLeft});
        end
        tick();
        checks++;
        if (oPacketValid !== 1'b0) begin
            errors++;
            $display("FAIL nominal_pv_width got %b exp 0", oPacketValid);
        end
    endtask

    task automatic test_clamp();
        logic [7:0]  pk [6][3];
        logic [16:0] ex [6];
        pk = '{'{8'h08, 8'h96, 8'h73}, '{8'h08, 8'h0A, 8'h05}, '{8'h18, 8'h00, 8'h00},
               '{8'h18, 8'hC5, 8'h00}, '{8'h18, 8'hF6, 8'h00}, '{8'h28, 8'h00, 8'h00}};
        ex = '{{9'd315, 8'd2}, {9'd319, 8'd0}, {9'd63, 8'd0},
               {9'd4, 8'd0},   {9'd0, 8'd0},   {9'd0, 8'd239}};
        for (int i = 0; i < 6; i++) begin
            send_packet(pk[i][0], pk[i][1], pk[i][2]);
            tick();
            checks++;
            if ({oMouseX, oMouseY} !== ex[i]) begin
                errors++;
                $display("FAIL clamp_%0d got X=%0d Y=%0d exp X=%0d Y=%0d",
                         i, oMouseX, oMouseY, ex[i][16:8], ex[i][7:0]);
            end
            tick();
        end
    endtask

    task automatic test_resync();
        send_byte(8'h00);
        tick();
        checks++;
        if (oPacketValid !== 1'b0) begin
            errors++;
            $display("FAIL resync_no_pv got %b exp 0", oPacketValid);
        end
        send_packet(8'h08, 8'h02, 8'h01);
        tick();
        checks++;
        if ({oMouseX, oMouseY, oPacketValid} !== {9'd2, 8'd238, 1'b1}) begin
            errors++;
            $display("FAIL resync_pos got X=%0d Y=%0d pv=%b exp X=2 Y=238 pv=1", oMouseX, oMouseY, oPacketValid);
        end
        tick();
    endtask

    task automatic test_timeout();
        send_byte(8'h08);
        repeat (100) tick();
        send_packet(8'h09, 8'h01, 8'h01);
        tick();
        checks++;
        if ({oMouseX, oMouseY} !== {9'd3, 8'd237}) begin
            errors++;
            $display("FAIL timeout_pos got X=%0d Y=%0d exp X=3 Y=237", oMouseX, oMouseY);
        end
        checks++;
        if ({oLeft, oClick, oPacketValid} !== 3'b111) begin
            errors++;
            $display("FAIL timeout_flags got left/click/pv=%b exp 111", {oLeft, oClick, oPacketValid});
        end
        tick();
        checks++;
        if (oClick !== 1'b0) begin
            errors++;
            $display("FAIL click_width got %b exp 0", oClick);
        end
        // A gap shorter than the timeout keeps the partial packet alive.
        send_byte(8'h08);
        repeat (50) tick();
        send_byte(8'h00);
        send_byte(8'h00);
        tick();
        checks++;
        if ({oMouseX, oMouseY, oLeft, oPacketValid} !== {9'd3, 8'd237, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL short_gap got X=%0d Y=%0d left=%b pv=%b exp X=3 Y=237 left=0 pv=1",
                     oMouseX, oMouseY, oLeft, oPacketValid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [7];
        logic       pv_exp [7];
        seq    = '{8'h48, 8'h7F, 8'h04, 8'h08, 8'h01, 8'h00, 8'h00};
        pv_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            iByte      = seq[i];
            iByteValid = (i < 6);
            tick();
            checks++;
            if (oPacketValid !== pv_exp[i]) begin
                errors++;
                $display("FAIL b2b_pv_%0d got %b exp %b", i, oPacketValid, pv_exp[i]);
            end
            if (i == 3) begin
                checks++;
                if ({oMouseX, oMouseY} !== {9'd3, 8'd233}) begin
                    errors++;
                    $display("FAIL ovf_pos got X=%0d Y=%0d exp X=3 Y=233", oMouseX, oMouseY);
                end
            end
        end
        iByteValid = 1'b0;
        checks++;
        if ({oMouseX, oMouseY} !== {9'd4, 8'd233}) begin
            errors++;
            $display("FAIL b2b_pos got X=%0d Y=%0d exp X=4 Y=233", oMouseX, oMouseY);
        end
        tick();
        checks++;
        if (oPacketValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pv_end got %b exp 0", oPacketValid);
        end
    endtask

    task automatic test_reset_mid_packet();
        send_packet(8'h09, 8'h00, 8'h00);
        tick();
        checks++;
        if ({oLeft, oClick} !== 2'b11) begin
            errors++;
            $display("FAIL press_before_reset got left/click=%b exp 11", {oLeft, oClick});
        end
        tick();
        send_byte(8'h08);
        send_byte(8'h05);
        iResetn = 1'b0;
        #2;
        checks++;
        if ({oMouseX, oMouseY, oLeft, oRight, oPacketValid, oClick} !== {9'd160, 8'd120, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset got X=%0d Y=%0d flags=%b exp X=160 Y=120 flags=0000",
                     oMouseX, oMouseY, {oLeft, oRight, oPacketValid, oClick});
        end
        tick();
        tick();
        iResetn = 1'b1;
        tick();
        send_packet(8'h0A, 8'h03, 8'h02);
        tick();
        checks++;
        if ({oMouseX, oMouseY, oRight, oPacketValid} !== {9'd163, 8'd118, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL post_reset got X=%0d Y=%0d right=%b pv=%b exp X=163 Y=118 right=1 pv=1",
                     oMouseX, oMouseY, oRight, oPacketValid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_clamp();
        test_resync();
        test_timeout();
        test_back_to_back();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mouse_tracker
`default_nettype wire
